// File: rtl/wolfram_ca_stepper.sv
// Elementary (Wolfram-rule) cellular automaton: CELLS cells share one run-time
// 8-bit rule and advance a requested number of generations per start/done run.
module wolfram_ca_stepper #(
    parameter int CELLS    = 16,
    parameter int BOUNDARY = 0,
    parameter int STEPS_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [7:0]         rule_in,
    input  logic [CELLS-1:0]   seed_in,
    input  logic [STEPS_W-1:0] steps_in,
    input  logic               hold,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic [CELLS-1:0]   state_out,
    output logic [STEPS_W-1:0] step_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t               state;
    fsm_t               state_next;
    logic [7:0]         rule;
    logic [7:0]         rule_next;
    logic [STEPS_W-1:0] steps;
    logic [STEPS_W-1:0] steps_next;
    logic [CELLS-1:0]   gen_next;
    logic [CELLS-1:0]   gen_stepped;
    logic [STEPS_W-1:0] count_next;
    logic [STEPS_W-1:0] count_inc;

    // The generation is padded with one neighbour on each side so every cell
    // reads a uniform 3-bit window {left, self, right} from the padded vector.
    function automatic logic [CELLS-1:0] next_generation(
        input logic [CELLS-1:0] cur,
        input logic [7:0]       r
    );
        logic [CELLS+1:0] ext;
        logic [CELLS-1:0] nxt;
        logic [2:0]       idx;
        if (BOUNDARY == 0) begin
            ext = {cur[0], cur, cur[CELLS-1]};
        end else begin
            ext = {1'b0, cur, 1'b0};
        end
        nxt = '0;
        for (int i = 0; i < CELLS; i++) begin
            idx    = ext[i +: 3];
            nxt[i] = r[idx];
        end
        return nxt;
    endfunction

    assign gen_stepped = next_generation(state_out, rule);

    always_comb begin
        state_next = state;
        rule_next  = rule;
        steps_next = steps;
        gen_next   = state_out;
        count_next = step_count;
        count_inc  = step_count + 1'b1;
        case (state)
            IDLE: begin
                if (start) begin
                    rule_next  = rule_in;
                    steps_next = steps_in;
                    gen_next   = seed_in;
                    count_next = '0;
                    state_next = (steps_in == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // abort outranks hold, which outranks stepping
                if (abort) begin
                    state_next = IDLE;
                end else if (!hold) begin
                    gen_next   = gen_stepped;
                    count_next = count_inc;
                    if (count_inc == steps) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // busy/done are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rule       <= '0;
            steps      <= '0;
            state_out  <= '0;
            step_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            rule       <= rule_next;
            steps      <= steps_next;
            state_out  <= gen_next;
            step_count <= count_next;
            busy       <= (state_next == RUN);
            done       <= (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_wolfram_ca_stepper.sv
// Bench for wolfram_ca_stepper: two 8-cell instances (periodic and null edge)
// driven in lockstep and compared against a transaction-level reference model.
module tb_wolfram_ca_stepper;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] rule_in;
    logic [7:0] seed_in;
    logic [7:0] steps_in;
    logic       hold;
    logic       abort;

    logic       busy0, done0, busy1, done1;
    logic [7:0] state0, state1, count0, count1;

    int checks   = 0;
    int failures = 0;
    bit abort_with_hold = 0;

    wolfram_ca_stepper #(.CELLS(8), .BOUNDARY(0), .STEPS_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .rule_in(rule_in),
        .seed_in(seed_in), .steps_in(steps_in), .hold(hold), .abort(abort),
        .busy(busy0), .done(done0), .state_out(state0), .step_count(count0)
    );

    wolfram_ca_stepper #(.CELLS(8), .BOUNDARY(1), .STEPS_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .rule_in(rule_in),
        .seed_in(seed_in), .steps_in(steps_in), .hold(hold), .abort(abort),
        .busy(busy1), .done(done1), .state_out(state1), .step_count(count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input bit b, input bit d,
                           input logic [7:0] e0, input logic [7:0] e1, input int cnt);
        chk({tag, "_busy0"},  32'(busy0),  32'(b));
        chk({tag, "_busy1"},  32'(busy1),  32'(b));
        chk({tag, "_done0"},  32'(done0),  32'(d));
        chk({tag, "_done1"},  32'(done1),  32'(d));
        chk({tag, "_state0"}, 32'(state0), 32'(e0));
        chk({tag, "_state1"}, 32'(state1), 32'(e1));
        chk({tag, "_count0"}, 32'(count0), 32'(cnt));
        chk({tag, "_count1"}, 32'(count1), 32'(cnt));
    endtask

    // Rule number read as a lookup: neighbourhood value 4*left + 2*self + right
    // selects the bit of the rule that becomes the new cell.
    function automatic logic [7:0] ref_step(input logic [7:0] c, input logic [7:0] r, input int bnd);
        logic [7:0] n;
        int l, m, rr, idx;
        for (int i = 0; i < 8; i++) begin
            m = int'(c[i]);
            if (i == 7) l = (bnd == 0) ? int'(c[0]) : 0;
            else        l = int'(c[i+1]);
            if (i == 0) rr = (bnd == 0) ? int'(c[7]) : 0;
            else        rr = int'(c[i-1]);
            idx  = 4 * l + 2 * m + rr;
            n[i] = ((int'(r) >> idx) & 1) != 0;
        end
        return n;
    endfunction

    task automatic run_case(input logic [7:0] rule, input logic [7:0] seed, input logic [7:0] steps,
                            input int hold_at, input int hold_len, input int abort_at,
                            input bit rnd_hold, input bit scramble, input string tag);
        logic [7:0] e0, e1;
        int  cnt, held, rnd_cnt;
        bit  fin, do_hold, do_abort;
        rule_in  = rule;
        seed_in  = seed;
        steps_in = steps;
        start    = 1'b1;
        hold     = 1'b0;
        abort    = 1'b0;
        @(posedge clk); #1;
        e0 = seed; e1 = seed; cnt = 0; held = 0; rnd_cnt = 0; fin = 0;
        if (!scramble) start = 1'b0;
        if (steps == 8'd0) begin
            chk_all({tag, "_zero"}, 1'b0, 1'b1, e0, e1, 0);
            start    = 1'b1;
            steps_in = 8'd5;
            @(posedge clk); #1;
            start = 1'b0;
            chk_all({tag, "_dstart"}, 1'b0, 1'b0, e0, e1, 0);
            @(posedge clk); #1;
            chk_all({tag, "_dstart2"}, 1'b0, 1'b0, e0, e1, 0);
            return;
        end
        for (int cyc = 0; cyc < int'(steps) + hold_len + 40 && !fin; cyc++) begin
            chk_all({tag, "_run"}, 1'b1, 1'b0, e0, e1, cnt);
            if (scramble) begin
                rule_in  = 8'($urandom);
                seed_in  = 8'($urandom);
                steps_in = 8'($urandom);
            end
            do_abort = (cnt == abort_at);
            do_hold  = 1'b0;
            if (cnt == hold_at && held < hold_len) begin
                do_hold = 1'b1;
                held++;
            end
            if (rnd_hold && rnd_cnt < 20 && $urandom_range(3) == 0) begin
                do_hold = 1'b1;
                rnd_cnt++;
            end
            if (do_abort && abort_with_hold) do_hold = 1'b1;
            hold  = do_hold;
            abort = do_abort;
            @(posedge clk); #1;
            hold  = 1'b0;
            abort = 1'b0;
            if (do_abort) begin
                fin   = 1;
                start = 1'b0;
                chk_all({tag, "_abort"}, 1'b0, 1'b0, e0, e1, cnt);
                @(posedge clk); #1;
                chk_all({tag, "_abort2"}, 1'b0, 1'b0, e0, e1, cnt);
            end else if (!do_hold) begin
                e0 = ref_step(e0, rule, 0);
                e1 = ref_step(e1, rule, 1);
                cnt++;
                if (cnt == int'(steps)) begin
                    fin   = 1;
                    start = 1'b0;
                    chk_all({tag, "_done"}, 1'b0, 1'b1, e0, e1, cnt);
                    @(posedge clk); #1;
                    chk_all({tag, "_idle"}, 1'b0, 1'b0, e0, e1, cnt);
                end
            end
        end
        if (!fin) chk({tag, "_timeout"}, 32'd0, 32'd1);
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; rule_in = '0; seed_in = '0;
        steps_in = '0; hold = 1'b0; abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 1'b0, 8'h00, 8'h00, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk_all("post_reset", 1'b0, 1'b0, 8'h00, 8'h00, 0);

        // identity rule
        run_case(8'hCC, 8'hA5, 8'd3, -1, 0, -1, 1'b0, 1'b0, "t1");
        chk("t1_state", 32'(state0), 32'h A5);
        chk("t1_count", 32'(count0), 32'd3);

        // asynchronous reset in the middle of a run
        rule_in = 8'hCC; seed_in = 8'h5A; steps_in = 8'd10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk_all("t1_rst", 1'b0, 1'b0, 8'h00, 8'h00, 0);
        @(posedge clk); #1;
        chk_all("t1_rst_hold", 1'b0, 1'b0, 8'h00, 8'h00, 0);
        @(negedge clk) rst_n = 1'b1;

        // wrap versus null edges
        run_case(8'hF0, 8'h01, 8'd1, -1, 0, -1, 1'b0, 1'b0, "t2a");
        chk("t2_wrap", 32'(state0), 32'h80);
        chk("t2_null", 32'(state1), 32'h00);
        run_case(8'hAA, 8'h80, 8'd1, -1, 0, -1, 1'b0, 1'b0, "t2b");
        chk("t2_wrap_l", 32'(state0), 32'h01);

        run_case(8'h51, 8'h00, 8'd3, -1, 0, -1, 1'b0, 1'b0, "t3");
        chk("t3_state", 32'(state0), 32'hFF);
        chk("t3_count", 32'(count0), 32'd3);

        run_case(8'h12, 8'h3C, 8'd0, -1, 0, -1, 1'b0, 1'b0, "t4");
        chk("t4_state", 32'(state0), 32'h3C);

        // hold for 4 cycles after step 2, abort after step 3
        run_case(8'hF0, 8'h01, 8'd5, 2, 4, 3, 1'b0, 1'b0, "t5");
        chk("t5_state", 32'(state0), 32'h20);
        chk("t5_count", 32'(count0), 32'd3);
        abort_with_hold = 1'b1;
        run_case(8'hF0, 8'h01, 8'd5, -1, 0, 1, 1'b0, 1'b0, "t5ah");
        chk("t5ah_state", 32'(state0), 32'h80);
        abort_with_hold = 1'b0;

        // inputs scrambled and start held high during the run
        run_case(8'hF0, 8'h01, 8'd5, -1, 0, -1, 1'b0, 1'b1, "t6");
        chk("t6_state", 32'(state0), 32'h08);
        chk("t6_count", 32'(count0), 32'd5);

        for (int k = 0; k < 25; k++) begin
            logic [7:0] r, s, n;
            int ab;
            r  = 8'($urandom);
            s  = 8'($urandom);
            n  = 8'($urandom_range(12));
            ab = (n != 0 && $urandom_range(3) == 0) ? int'($urandom_range(int'(n) - 1)) : -1;
            abort_with_hold = 1'($urandom_range(1));
            run_case(r, s, n, -1, 0, ab, 1'($urandom_range(1)), 1'($urandom_range(1)), "rnd");
            repeat ($urandom_range(2)) @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
